// File: rtl/mshr_mem_issue.sv
// mshr_mem_issue: pops one MSHR entry at a time and issues it to memory as a
// read or a write. It then waits for the response, reissuing the request on
// timeout. Finally it returns a fill/completion to the cache and frees the
// MSHR entry.
//
// Request handshake: mem_req_valid_o is raised in REQ and stays high, with
// we/addr/data stable, until the cycle in which mem_req_ready_i is also high.
// The transfer happens on that rising clock edge. No other condition
// withdraws valid, except enable_i=0, which masks every strobe.
module mshr_mem_issue #(
  parameter int ADDR_BITS     = 20,
  parameter int DATA_BITS     = 90,
  parameter int MSHR_TAG_BITS = 3,
  parameter int CPU_ID_BITS   = 2,
  parameter int ASSOC_BITS    = 2,
  parameter int TIMEOUT_BITS  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  // MSHR read-next port
  input  logic                     rn_valid_i,
  input  logic [ADDR_BITS-1:0]     rn_addr_i,
  input  logic [DATA_BITS-1:0]     rn_data_i,
  input  logic                     rn_rw_i,
  input  logic                     rn_dirty_i,
  input  logic [CPU_ID_BITS-1:0]   rn_cpu_id_i,
  input  logic [ASSOC_BITS-1:0]    rn_victim_i,
  input  logic [MSHR_TAG_BITS-1:0] rn_mshr_id_i,
  output logic                     read_next_o,
  // MSHR delete port
  output logic                     del_o,
  output logic [MSHR_TAG_BITS-1:0] del_tag_o,
  // memory request / response
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic                     mem_req_we_o,
  output logic [ADDR_BITS-1:0]     mem_req_addr_o,
  output logic [DATA_BITS-1:0]     mem_req_data_o,
  input  logic                     mem_resp_valid_i,
  input  logic [DATA_BITS-1:0]     mem_resp_data_i,
  // fill / completion to the cache
  output logic                     fill_valid_o,
  output logic [ADDR_BITS-1:0]     fill_addr_o,
  output logic [DATA_BITS-1:0]     fill_data_o,
  output logic                     fill_rw_o,
  output logic                     fill_dirty_o,
  output logic [CPU_ID_BITS-1:0]   fill_cpu_id_o,
  output logic [ASSOC_BITS-1:0]    fill_victim_o,
  output logic [MSHR_TAG_BITS-1:0] fill_mshr_id_o,
  // status and debug
  output logic                     timeout_err_o,
  output logic [7:0]               retry_count_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [TIMEOUT_BITS-1:0]   wait_cnt_q, wait_cnt_d;

  // holding registers for the single in-flight entry
  logic [ADDR_BITS-1:0]      h_addr_q;
  logic [DATA_BITS-1:0]      h_data_q;
  logic                      h_rw_q;
  logic                      h_dirty_q;
  logic [CPU_ID_BITS-1:0]    h_cpu_id_q;
  logic [ASSOC_BITS-1:0]     h_victim_q;
  logic [MSHR_TAG_BITS-1:0]  h_mshr_id_q;
  logic [DATA_BITS-1:0]      resp_data_q;

  logic                      timeout_err_q;
  logic [7:0]                retry_cnt_q;

  // decoded per-cycle actions
  logic                      pop;
  logic                      req_valid;
  logic                      fill_valid;
  logic                      resp_take;
  logic                      timeout_hit;

  // Next-state and strobe decode. enable_i=0 leaves every action low, so the
  // state and all registers hold their values.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pop         = 1'b0;
    req_valid   = 1'b0;
    fill_valid  = 1'b0;
    resp_take   = 1'b0;
    timeout_hit = 1'b0;
    if (enable_i) begin
      unique case (state_q)
        IDLE: begin
          if (rn_valid_i) begin
            pop     = 1'b1;
            state_d = REQ;
          end
        end
        REQ: begin
          req_valid = 1'b1;
          if (mem_req_ready_i) begin
            state_d    = WAIT;
            wait_cnt_d = '0;
          end
        end
        WAIT: begin
          if (mem_resp_valid_i) begin
            resp_take = 1'b1;
            state_d   = FILL;
          end else if (wait_cnt_q == '1) begin
            // Give up on this attempt and resend the identical request.
            timeout_hit = 1'b1;
            state_d     = REQ;
          end else begin
            wait_cnt_d = wait_cnt_q + TIMEOUT_BITS'(1);
          end
        end
        FILL: begin
          fill_valid = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and response-wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Capture the MSHR head on pop, and capture read data when the response arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_addr_q    <= '0;
      h_data_q    <= '0;
      h_rw_q      <= 1'b0;
      h_dirty_q   <= 1'b0;
      h_cpu_id_q  <= '0;
      h_victim_q  <= '0;
      h_mshr_id_q <= '0;
      resp_data_q <= '0;
    end else begin
      if (pop) begin
        h_addr_q    <= rn_addr_i;
        h_data_q    <= rn_data_i;
        h_rw_q      <= rn_rw_i;
        h_dirty_q   <= rn_dirty_i;
        h_cpu_id_q  <= rn_cpu_id_i;
        h_victim_q  <= rn_victim_i;
        h_mshr_id_q <= rn_mshr_id_i;
      end
      if (resp_take && !h_rw_q) begin
        resp_data_q <= mem_resp_data_i;
      end
    end
  end

  // Sticky timeout flag and saturating retry counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_err_q <= 1'b0;
      retry_cnt_q   <= '0;
    end else if (timeout_hit) begin
      timeout_err_q <= 1'b1;
      if (retry_cnt_q != 8'hFF) begin
        retry_cnt_q <= retry_cnt_q + 8'd1;
      end
    end
  end

  // Strobes are driven from decoded state. Request and fill fields come
  // straight from the holding registers, so they stay stable while valid is high.
  assign read_next_o     = pop;
  assign mem_req_valid_o = req_valid;
  assign mem_req_we_o    = h_rw_q;
  assign mem_req_addr_o  = h_addr_q;
  assign mem_req_data_o  = h_rw_q ? h_data_q : '0;

  assign fill_valid_o    = fill_valid;
  assign del_o           = fill_valid;
  assign del_tag_o       = h_mshr_id_q;
  assign fill_addr_o     = h_addr_q;
  assign fill_data_o     = h_rw_q ? h_data_q : resp_data_q;
  assign fill_rw_o       = h_rw_q;
  assign fill_dirty_o    = h_dirty_q;
  assign fill_cpu_id_o   = h_cpu_id_q;
  assign fill_victim_o   = h_victim_q;
  assign fill_mshr_id_o  = h_mshr_id_q;

  assign timeout_err_o   = timeout_err_q;
  assign retry_count_o   = retry_cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_mshr_mem_issue.sv
// Bench for mshr_mem_issue. It contains an MSHR queue model, a memory
// responder, and a fill scoreboard fed at response time.
module tb_mshr_mem_issue;

  localparam int AW  = 20;
  localparam int DW  = 90;
  localparam int TW  = 3;
  localparam int CW  = 2;
  localparam int VW  = 2;
  localparam int TOB = 3;
  localparam int FW  = AW + DW + 1 + 1 + CW + VW + TW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rw;
    logic          dirty;
    logic [CW-1:0] cpu;
    logic [VW-1:0] victim;
    logic [TW-1:0] tag;
  } entry_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  initial forever #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          rn_valid, rn_rw, rn_dirty;
  logic [AW-1:0] rn_addr;
  logic [DW-1:0] rn_data;
  logic [CW-1:0] rn_cpu_id;
  logic [VW-1:0] rn_victim;
  logic [TW-1:0] rn_mshr_id;
  logic          read_next, del;
  logic [TW-1:0] del_tag;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          fill_valid, fill_rw, fill_dirty;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic [CW-1:0] fill_cpu_id;
  logic [VW-1:0] fill_victim;
  logic [TW-1:0] fill_mshr_id;
  logic          timeout_err;
  logic [7:0]    retry_count;
  logic [1:0]    state;

  mshr_mem_issue #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .MSHR_TAG_BITS(TW),
    .CPU_ID_BITS(CW), .ASSOC_BITS(VW), .TIMEOUT_BITS(TOB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .rn_valid_i(rn_valid), .rn_addr_i(rn_addr), .rn_data_i(rn_data),
    .rn_rw_i(rn_rw), .rn_dirty_i(rn_dirty), .rn_cpu_id_i(rn_cpu_id),
    .rn_victim_i(rn_victim), .rn_mshr_id_i(rn_mshr_id),
    .read_next_o(read_next), .del_o(del), .del_tag_o(del_tag),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_we_o(mem_req_we), .mem_req_addr_o(mem_req_addr),
    .mem_req_data_o(mem_req_data),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_data_i(mem_resp_data),
    .fill_valid_o(fill_valid), .fill_addr_o(fill_addr), .fill_data_o(fill_data),
    .fill_rw_o(fill_rw), .fill_dirty_o(fill_dirty), .fill_cpu_id_o(fill_cpu_id),
    .fill_victim_o(fill_victim), .fill_mshr_id_o(fill_mshr_id),
    .timeout_err_o(timeout_err), .retry_count_o(retry_count), .state_o(state)
  );

  // ---------------- bench state ----------------
  entry_t        mq[$];          // MSHR model contents, head at index 0
  entry_t        inflight;       // entry the DUT popped most recently
  bit            busy;           // an entry is popped but not yet filled
  int            ready_hold;     // request cycles still to refuse
  int            resp_lat;       // WAIT cycle (1-based) carrying the response
  int            drop_n;         // accepted requests to leave unanswered
  bit            resp_rand;
  logic [DW-1:0] resp_pat;
  logic [FW-1:0] exp_q[$];       // scoreboard of expected fills
  int            cyc, pop_cyc, req_cyc, fill_cyc, fill_count;
  int            req_run, last_req_run;
  int            fire_cyc_q[$];
  int            fill_cyc_q[$];
  int            n_vec, n_err;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic entry_t make_entry(input logic [AW-1:0] a, input logic rw,
                                        input logic [DW-1:0] d, input logic [TW-1:0] t,
                                        input logic [VW-1:0] v);
    entry_t e;
    e.addr   = a;
    e.data   = d;
    e.rw     = rw;
    e.dirty  = 1'($urandom_range(0, 1));
    e.cpu    = CW'($urandom_range(0, 3));
    e.victim = v;
    e.tag    = t;
    return e;
  endfunction

  // Every control-ish output packed together; all zero in reset.
  function automatic logic [127:0] ctl_vec();
    return 128'({read_next, del, del_tag, mem_req_valid, mem_req_we, mem_req_addr,
                 fill_valid, fill_addr, fill_rw, fill_dirty, fill_cpu_id, fill_victim,
                 fill_mshr_id, timeout_err, retry_count, state});
  endfunction

  // ---------------- MSHR model (driver) ----------------
  initial begin
    bit     pop;
    entry_t h;
    rn_valid = 1'b0; rn_addr = '0; rn_data = '0; rn_rw = 1'b0; rn_dirty = 1'b0;
    rn_cpu_id = '0; rn_victim = '0; rn_mshr_id = '0;
    forever begin
      @(negedge clk);
      pop = read_next;
      @(posedge clk); #1;
      if (pop && rst_n && mq.size() > 0) begin
        inflight = mq.pop_front();
        busy     = 1'b1;
      end
      if (mq.size() > 0) begin
        h = mq[0];
        rn_valid = 1'b1; rn_addr = h.addr; rn_data = h.data; rn_rw = h.rw;
        rn_dirty = h.dirty; rn_cpu_id = h.cpu; rn_victim = h.victim; rn_mshr_id = h.tag;
      end else begin
        rn_valid = 1'b0;
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    bit            fire;
    int            cd;
    entry_t        e;
    logic [DW-1:0] d;
    cd = 0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      fire = mem_req_valid && mem_req_ready;
      if (mem_req_valid && !mem_req_ready && ready_hold > 0) ready_hold--;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (fire) begin
          if (drop_n > 0) begin
            drop_n--;
            cd = 0;
          end else begin
            cd = resp_lat;
          end
        end
        if (cd > 0) begin
          if (cd == 1) begin
            d = resp_rand ? rand_data() : resp_pat;
            mem_resp_valid = 1'b1;
            mem_resp_data  = d;
            e = inflight;
            if (!e.rw) e.data = d;
            exp_q.push_back(FW'(e));
          end
          cd--;
        end
      end
      mem_req_ready = (ready_hold == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    entry_t        got;
    logic [FW-1:0] exp;
    logic [DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (!enable) begin
          check("strobes_off", 128'({read_next, del, mem_req_valid, fill_valid}), 128'(0));
        end
        if (read_next) begin
          check("rn_while_busy", 128'(busy), 128'(0));
          pop_cyc = cyc;
        end
        if (mem_req_valid) begin
          exp_d = inflight.rw ? inflight.data : '0;
          check("req_fields", 128'({mem_req_addr, mem_req_we}), 128'({inflight.addr, inflight.rw}));
          check("req_data", 128'(mem_req_data), 128'(exp_d));
          if (req_run == 0) req_cyc = cyc;
          req_run++;
          if (mem_req_ready) begin
            last_req_run = req_run;
            req_run = 0;
            fire_cyc_q.push_back(cyc);
          end
        end
        if (del || fill_valid) begin
          check("del_with_fill", 128'({del, del_tag}), 128'({fill_valid, fill_mshr_id}));
        end
        if (fill_valid) begin
          got = '{addr: fill_addr, data: fill_data, rw: fill_rw, dirty: fill_dirty,
                  cpu: fill_cpu_id, victim: fill_victim, tag: fill_mshr_id};
          check("fill_expected", 128'(exp_q.size() > 0), 128'(1));
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("fill_fields", 128'(got), 128'(exp));
          end
          fill_cyc = cyc;
          fill_cyc_q.push_back(cyc);
          fill_count++;
          busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_fills(input int target, input int budget);
    int n = 0;
    while (fill_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("fill_wait", 128'(fill_count >= target), 128'(1));
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget);
    int n = 0;
    while (state !== st && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("state_wait", 128'(state), 128'(st));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    n_vec = 0; n_err = 0; cyc = 0; fill_count = 0; busy = 1'b0;
    req_run = 0; last_req_run = 0; pop_cyc = 0; req_cyc = 0; fill_cyc = 0;
    ready_hold = 0; resp_lat = 1; drop_n = 0; resp_rand = 1'b1; resp_pat = '0;
    inflight = '0;
    rst_n = 1'b0; enable = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", ctl_vec(), 128'(0));
    check("rst_req_data", 128'(mem_req_data), 128'(0));
    check("rst_fill_data", 128'(fill_data), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // read miss with fixed response data
    resp_rand = 1'b0;
    resp_pat  = DW'('hABC);
    mq.push_back(make_entry(20'h01234, 1'b0, rand_data(), 3'd5, 2'd2));
    wait_fills(1, 40);
    check("rd_req_lat", 128'(req_cyc - pop_cyc), 128'(1));
    check("rd_fill_lat", 128'(fill_cyc - pop_cyc), 128'(3));
    check("rd_fill_data", 128'(fill_data), 128'('hABC));

    // write: fill carries the held data, never the response data
    resp_rand = 1'b1;
    mq.push_back(make_entry(20'h0BEEF, 1'b1, DW'('h55), 3'd1, 2'd0));
    wait_fills(2, 40);
    check("wr_fill_data", 128'({fill_rw, fill_data}), 128'({1'b1, DW'('h55)}));
    check("wr_del_tag", 128'(del_tag), 128'(1));

    // backpressure: ready low for 5 request cycles, second entry queued behind
    ready_hold = 5;
    mq.push_back(make_entry(AW'($urandom), 1'b0, rand_data(), 3'd3, 2'd1));
    mq.push_back(make_entry(AW'($urandom), 1'b1, rand_data(), 3'd4, 2'd3));
    wait_fills(3, 60);
    check("bp_valid_len", 128'(last_req_run), 128'(6));
    wait_fills(4, 40);

    // timeout: first attempt dropped, reissue answered
    check("to_err_before", 128'({timeout_err, retry_count}), 128'(0));
    fire_cyc_q.delete();
    drop_n = 1;
    mq.push_back(make_entry(AW'($urandom), 1'b0, rand_data(), 3'd6, 2'd2));
    wait_fills(5, 100);
    check("to_err", 128'(timeout_err), 128'(1));
    check("to_cnt", 128'(retry_count), 128'(1));
    check("to_fires", 128'(fire_cyc_q.size()), 128'(2));
    if (fire_cyc_q.size() >= 2) begin
      check("to_reissue_gap", 128'(fire_cyc_q[1] - fire_cyc_q[0]), 128'(9));
    end
    repeat (10) @(negedge clk);
    #1;
    check("to_single_fill", 128'(fill_count), 128'(5));

    // back-to-back: three queued entries
    fill_cyc_q.delete();
    for (int i = 0; i < 3; i++) begin
      mq.push_back(make_entry(AW'($urandom), 1'($urandom_range(0, 1)), rand_data(), TW'(i), VW'(i)));
    end
    wait_fills(8, 100);
    check("b2b_count", 128'(fill_cyc_q.size()), 128'(3));
    if (fill_cyc_q.size() == 3) begin
      check("b2b_gap0", 128'(fill_cyc_q[1] - fill_cyc_q[0]), 128'(4));
      check("b2b_gap1", 128'(fill_cyc_q[2] - fill_cyc_q[1]), 128'(4));
    end

    // retry counter saturation
    drop_n = 258;
    mq.push_back(make_entry(AW'($urandom), 1'b0, rand_data(), 3'd7, 2'd0));
    wait_fills(9, 3000);
    check("retry_sat", 128'(retry_count), 128'(255));

    // enable low for 3 cycles while in REQ
    ready_hold = 2;
    mq.push_back(make_entry(AW'($urandom), 1'b1, rand_data(), 3'd2, 2'd1));
    wait_state(2'd1, 20);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("en_hold_state", 128'({state, mem_req_valid}), 128'({2'd1, 1'b0}));
    end
    @(posedge clk); #1;
    enable = 1'b1;
    wait_fills(10, 40);

    // asynchronous reset while waiting for a response that never comes
    drop_n = 1000;
    mq.push_back(make_entry(AW'($urandom), 1'b1, rand_data(), 3'd3, 2'd3));
    wait_state(2'd2, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctl", ctl_vec(), 128'(0));
    check("arst_req_data", 128'(mem_req_data), 128'(0));
    check("arst_fill_data", 128'(fill_data), 128'(0));
    mq.delete();
    busy   = 1'b0;
    drop_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("arst_idle", 128'({state, timeout_err, retry_count}), 128'(0));

    // normal operation after reset
    mq.push_back(make_entry(AW'($urandom), 1'b0, rand_data(), 3'd4, 2'd2));
    wait_fills(11, 40);
    repeat (3) @(negedge clk);
    #1;
    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
